// File: rtl/clk_div_sel.sv
// ---------------------------------------------------------------------------
// clk_div_sel
//
// Rate-selectable divided-clock / clock-enable generator. A four-entry table
// of half-periods (HALF0..HALF3, in clk_in cycles) is indexed by the rate
// currently in effect. Requested rate and output mode are only adopted on a
// full-period boundary, so clk_out never produces a runt high or low phase.
//
// Ports:
//   clk_in      in   1  system clock, all logic on its rising edge
//   rst_n       in   1  synchronous active-low reset
//   en          in   1  count enable; 0 freezes the divider
//   sel         in   2  requested rate index
//   mode        in   1  requested output mode (0 = square, 1 = pulse)
//   clk_out     out  1  divided output (registered)
//   tick        out  1  one-cycle strobe per full period (registered)
//   active_sel  out  2  rate index currently in effect
// ---------------------------------------------------------------------------
module clk_div_sel #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned HALF0 = 5_000_000,
    parameter int unsigned HALF1 = 2_500_000,
    parameter int unsigned HALF2 = 1_250_000,
    parameter int unsigned HALF3 = 625_000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] sel,
    input  logic       mode,
    output logic       clk_out,
    output logic       tick,
    output logic [1:0] active_sel
);

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ph_q, ph_d;
    logic [1:0]       active_sel_q, active_sel_d;
    mode_e            active_mode_q, active_mode_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;

    logic [CNT_W-1:0] term_cnt;
    logic             at_term;

    // Terminal count for the rate in effect (HALF - 1).
    always_comb begin
        unique case (active_sel_q)
            2'd0:    term_cnt = CNT_W'(HALF0 - 1);
            2'd1:    term_cnt = CNT_W'(HALF1 - 1);
            2'd2:    term_cnt = CNT_W'(HALF2 - 1);
            default: term_cnt = CNT_W'(HALF3 - 1);
        endcase
    end

    assign at_term = (cnt_q == term_cnt);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        cnt_d         = cnt_q;
        ph_d          = ph_q;
        active_sel_d  = active_sel_q;
        active_mode_d = active_mode_q;
        tick_d        = 1'b0;
        clk_out_d     = clk_out_q;

        if (en) begin
            if (at_term) begin
                cnt_d = '0;
                ph_d  = ~ph_q;
                // Leaving the high phase closes a full period: strobe and
                // adopt the requested rate/mode for the next period.
                if (ph_q) begin
                    tick_d        = 1'b1;
                    active_sel_d  = sel;
                    active_mode_d = mode_e'(mode);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Mode adopted at a boundary already governs the boundary's own
            // output value; in both modes that value is the period start.
            clk_out_d = (active_mode_d == MODE_PULSE) ? tick_d : ph_d;
        end else if (active_mode_q == MODE_PULSE) begin
            clk_out_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            ph_q          <= 1'b0;
            active_sel_q  <= 2'd0;
            active_mode_q <= MODE_SQUARE;
            tick_q        <= 1'b0;
            clk_out_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            ph_q          <= ph_d;
            active_sel_q  <= active_sel_d;
            active_mode_q <= active_mode_d;
            tick_q        <= tick_d;
            clk_out_q     <= clk_out_d;
        end
    end

    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign active_sel = active_sel_q;

endmodule

// File: tb/tb_clk_div_sel.sv
// ---------------------------------------------------------------------------
// tb_clk_div_sel
//
// Scoreboard bench for clk_div_sel (HALF = 4,2,1,8). The stimulus process
// drives inputs on the falling edge, advances a period-position reference
// model and queues the expected post-edge outputs; the monitor pops one entry
// after every rising edge and compares clk_out, tick and active_sel.
// ---------------------------------------------------------------------------
module tb_clk_div_sel;

    localparam int HALF_TAB [4] = '{4, 2, 1, 8};

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       en     = 1'b0;
    logic [1:0] sel    = 2'd0;
    logic       mode   = 1'b0;
    logic       clk_out;
    logic       tick;
    logic [1:0] active_sel;

    clk_div_sel #(
        .CNT_W (8),
        .HALF0 (4),
        .HALF1 (2),
        .HALF2 (1),
        .HALF3 (8)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .sel        (sel),
        .mode       (mode),
        .clk_out    (clk_out),
        .tick       (tick),
        .active_sel (active_sel)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       clk_out;
        logic       tick;
        logic [1:0] asel;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: position inside the current full period (0..2H-1).
    int       m_pos   = 0;
    bit [1:0] m_sel   = 0;
    bit       m_mode  = 0;
    bit       m_tick  = 0;
    bit       m_clk   = 0;

    task automatic check(input string name, input logic [1:0] act,
                         input logic [1:0] req, input int c);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, req);
    endtask

    task automatic model_step(input bit r, input bit e, input bit [1:0] s, input bit m);
        if (!r) begin
            m_pos  = 0;
            m_sel  = 0;
            m_mode = 0;
            m_tick = 0;
            m_clk  = 0;
        end else if (e) begin
            m_pos++;
            m_tick = 0;
            if (m_pos == 2 * HALF_TAB[m_sel]) begin
                m_pos  = 0;
                m_tick = 1;
                m_sel  = s;
                m_mode = m;
            end
            m_clk = m_mode ? m_tick : (m_pos >= HALF_TAB[m_sel]);
        end else begin
            m_tick = 0;
            if (m_mode) m_clk = 0;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit [1:0] s, input bit m);
        exp_t x;
        @(negedge clk_in);
        rst_n = r;
        en    = e;
        sel   = s;
        mode  = m;
        model_step(r, e, s, m);
        cyc++;
        x.clk_out = m_clk;
        x.tick    = m_tick;
        x.asel    = m_sel;
        x.cyc     = cyc;
        exp_q.push_back(x);
    endtask

    task automatic run(input int n, input bit e, input bit [1:0] s, input bit m);
        for (int i = 0; i < n; i++) step(1'b1, e, s, m);
    endtask

    // Monitor: compare one queued expectation after every rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("clk_out",    {1'b0, clk_out}, {1'b0, x.clk_out}, x.cyc);
                check("tick",       {1'b0, tick},    {1'b0, x.tick},    x.cyc);
                check("active_sel", active_sel,      x.asel,            x.cyc);
            end
        end
    end

    initial begin
        bit       r, e, m;
        bit [1:0] s;
        int       budget;

        // Reset, then the default square wave at HALF=4.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd0, 1'b0);
        run(5, 1'b1, 2'd0, 1'b0);
        // Request HALF=8 mid-high phase; adopted at the next boundary.
        run(30, 1'b1, 2'd3, 1'b0);
        // HALF=1: toggle every cycle.
        run(12, 1'b1, 2'd2, 1'b0);
        // Pulse mode at HALF=2.
        run(20, 1'b1, 2'd1, 1'b1);
        // Back to square HALF=4, pause mid-high, resume.
        run(13, 1'b1, 2'd0, 1'b0);
        run(10, 1'b0, 2'd0, 1'b0);
        run(12, 1'b1, 2'd0, 1'b0);
        // Pause while in pulse mode.
        run(9, 1'b1, 2'd1, 1'b1);
        run(4, 1'b0, 2'd1, 1'b1);
        run(6, 1'b1, 2'd1, 1'b1);
        // Single-cycle reset mid-period, then restart.
        run(7, 1'b1, 2'd3, 1'b0);
        step(1'b0, 1'b1, 2'd3, 1'b0);
        run(20, 1'b1, 2'd0, 1'b0);

        // Randomized traffic.
        s = 0;
        m = 0;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 149) != 0);
            e = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0)  s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) m = ~m;
            step(r, e, s, m);
        end

        // Drain the scoreboard within a bounded number of cycles.
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk_in);
            budget--;
        end
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_sel.md
# clk_div_sel

Parametrised, rate-selectable clock-enable/divided-clock generator driven from the board clock. It replaces the fixed-rate 10 Hz divider with a four-entry rate table chosen at run time by a select input. Rate and mode changes are applied only on full-period boundaries, so the output never glitches. It adds a one-cycle `tick` strobe, a pause enable and a pulse output mode. It feeds switch-controlled LED shifters and any logic that needs a slow, selectable-rate enable.

## Interface

Parameters:
- `CNT_W`, 32: counter width; must hold the largest HALFn−1.
- `HALF0`, 5_000_000: half-period in `clk_in` cycles for sel=0 (10 Hz at 100 MHz).
- `HALF1`, 2_500_000: half-period for sel=1.
- `HALF2`, 1_250_000: half-period for sel=2.
- `HALF3`, 625_000: half-period for sel=3.
- Every HALFn ≥ 1; 0 is illegal and not supported.

Ports:
- `clk_in`, in, 1: single system clock; all logic is on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `en`, in, 1: count enable; 0 freezes the divider.
- `sel`, in, 2: requested rate index; typically wired to `sw[3:2]`.
- `mode`, in, 1: requested output mode; 0 = square wave, 1 = pulse.
- `clk_out`, out, 1: divided output, registered.
- `tick`, out, 1: one-cycle strobe, once per full period, registered.
- `active_sel`, out, 2: rate index currently in effect.

## Operation

Registers:
- `cnt` (CNT_W bits)
- `ph` (phase)
- `active_sel`
- `active_mode`
- `tick`
- `clk_out`

Reset (`rst_n`=0 at a rising edge) forces all of the following, with priority over `en`:
- `cnt`=0, `ph`=0, `clk_out`=0, `tick`=0
- `active_sel`=0, `active_mode`=0

Reset applied mid-period aborts the period immediately; no partial pulse or tick follows.

Terminal count is `cnt == HALF[active_sel]−1`.

When `en`=1:
- Not at terminal count: `cnt` increments.
- At terminal count: `cnt`←0 and `ph` toggles.
- When the terminal count toggles `ph` 1→0 (full-period boundary):
  - `tick`←1 for exactly one cycle.
  - `active_sel`←`sel` and `active_mode`←`mode`; the new values govern the very next count.
- At all other times `tick`←0.

When `en`=0:
- `cnt`, `ph`, `active_sel` and `active_mode` hold.
- `tick`←0.
- `clk_out` holds in square mode and is forced to 0 in pulse mode.
- Re-enabling resumes from the held `cnt` with no lost or extra cycles.

Output modes:
- Square (`active_mode`=0): `clk_out` follows the next-state value of `ph`. It is high for HALF cycles and low for HALF cycles, for a period of 2·HALF.
- Pulse (`active_mode`=1): `clk_out` equals the next-state value of `tick`. It is high for one cycle per 2·HALF cycles.

Changes to `sel` or `mode` between boundaries are ignored until the next boundary; only the value present at the boundary is taken. If `sel` changes in the same cycle as the boundary, the new value is captured.

With HALF=1, `clk_out` toggles every cycle, i.e. `clk_in`/2, and `tick` fires every 2 cycles.

Counter arithmetic is unsigned CNT_W. `cnt` never exceeds HALF−1, so it never wraps.

## Timing

- Edges are numbered from the first rising edge with `rst_n`=1 and `en`=1 as edge 1.
- In square mode `clk_out` goes 1 after edge H, where H = HALF[active_sel].
- `clk_out` goes 0 and `tick` goes 1 after edge 2H; `tick` returns to 0 after edge 2H+1.
- Latency from a `sel` change to the new rate is at most one full old period, 2·HALF_old cycles, plus 1.
- `active_sel` updates in the same cycle that `tick` rises.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

All scenarios use HALF0=4, HALF1=2, HALF2=1, HALF3=8, with `rst_n` pulsed low for 3 cycles first.

1. Reset, `sel`=0, `mode`=0, `en`=1. Required:
   - `clk_out` high on cycles 5–8, low on cycles 9–12, repeating.
   - `tick`=1 only on cycles 9, 17, 25.
   - All outputs 0 during reset.
2. Running at sel=0, change `sel` to 3 at cycle 6. Required:
   - The current 8-cycle period completes.
   - `active_sel`=3 from cycle 9.
   - The next high phase lasts 8 cycles.
3. `sel`=2 (HALF=1). Required:
   - `clk_out` toggles every cycle.
   - `tick` fires every 2nd cycle.
4. `mode`=1, `sel`=1, checked after the first boundary. Required:
   - `clk_out` is a single-cycle pulse every 4 cycles, coincident with `tick`.
5. `en`=0 for 10 cycles starting mid-high phase (cycle 6). Required:
   - `clk_out` holds 1 and `tick` stays 0.
   - After re-enable the remaining 2 high cycles complete, then the normal sequence continues.
6. Assert `rst_n`=0 at cycle 7 for 1 cycle. Required:
   - Next cycle: `clk_out`=0, `tick`=0, `active_sel`=0.
   - Counting restarts from edge 1.
